// File: rtl/rdma_wr_gate_ul_pkg.sv
// rdma_wr_gate_ul_pkg: shared widths, request layout and beat/keep helpers for rdma_wr_gate_ul
package rdma_wr_gate_ul_pkg;
  localparam int DATA_BITS = 512;
  localparam int BEAT_BYTES = DATA_BITS / 8;
  localparam int OFF_BITS = $clog2(BEAT_BYTES);
  localparam int REQ_BITS = 128;
  localparam int LEN_BITS = 28;
  typedef struct packed {
    logic [REQ_BITS-LEN_BITS-64-1:0] ctl;
    logic [63:0] vaddr;
    logic [LEN_BITS-1:0] len;
  } req_t;
  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;
  function automatic logic [LEN_BITS-1:0] beat_cnt(input logic [LEN_BITS-1:0] len);
    return (len >> OFF_BITS) + LEN_BITS'(|len[OFF_BITS-1:0]);
  endfunction
  function automatic logic [BEAT_BYTES-1:0] keep_mask(input logic [LEN_BITS-1:0] len);
    return ~(len[OFF_BITS-1:0] == '0 ? '0 : {BEAT_BYTES{1'b1}} << len[OFF_BITS-1:0]);
  endfunction
endpackage

// File: rtl/rdma_wr_gate_ul_if.sv
// rdma_wr_gate_ul_if: write-request plus AXI4-Stream write-data bundle
interface rdma_wr_gate_ul_if;
  import rdma_wr_gate_ul_pkg::*;
  logic req_valid;
  logic req_ready;
  req_t req_data;
  logic tvalid;
  logic tready;
  logic [DATA_BITS-1:0] tdata;
  logic [BEAT_BYTES-1:0] tkeep;
  logic tlast;
  modport master (output req_valid, req_data, tvalid, tdata, tkeep, tlast, input req_ready, tready);
  modport slave (input req_valid, req_data, tvalid, tdata, tkeep, tlast, output req_ready, tready);
endinterface

// File: rtl/rdma_wr_gate_skid.sv
// rdma_wr_gate_skid: 2-entry AXI4-Stream skid buffer, 1-cycle latency, one beat per cycle
module rdma_wr_gate_skid #(parameter int W = 8) (
  input  logic aclk,
  input  logic aresetn,
  input  logic i_valid,
  output logic o_ready,
  input  logic [W-1:0] i_data,
  output logic o_valid,
  input  logic i_ready,
  output logic [W-1:0] o_data
);
  logic r_out_v, r_sk_v;
  logic [W-1:0] r_out_d, r_sk_d;
  assign o_ready = !r_sk_v;
  assign o_valid = r_out_v;
  assign o_data = r_out_d;
  // output register refills from the skid entry first; a stalled output parks the incoming beat in the skid entry
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_out_v <= 1'b0;
      r_sk_v <= 1'b0;
      r_out_d <= '0;
      r_sk_d <= '0;
    end else if (i_ready || !r_out_v) begin
      r_out_v <= r_sk_v || i_valid;
      r_out_d <= r_sk_v ? r_sk_d : i_data;
      r_sk_v <= 1'b0;
    end else if (i_valid && !r_sk_v) begin
      r_sk_v <= 1'b1;
      r_sk_d <= i_data;
    end
endmodule

// File: rtl/rdma_wr_gate_ul.sv
// rdma_wr_gate_ul: pairs RDMA write requests with their data beats, regenerates tlast/tkeep, flags length mismatches.
// Define RDMA_WR_GATE_STATS_EN to add the stat_req_cnt/stat_beat_cnt handshake counters.
module rdma_wr_gate_ul
  import rdma_wr_gate_ul_pkg::*;
#(parameter int QDEPTH = 8) (
  input  logic aclk,
  input  logic aresetn,
  rdma_wr_gate_ul_if.slave s,
  rdma_wr_gate_ul_if.master m,
  output logic err_len,
  input  logic err_clr
`ifdef RDMA_WR_GATE_STATS_EN
  ,
  output logic [31:0] stat_req_cnt,
  output logic [31:0] stat_beat_cnt
`endif
);
  localparam int AW = $clog2(QDEPTH);
  localparam int SW = DATA_BITS + BEAT_BYTES + 1;
  req_t r_mem [QDEPTH];
  logic [AW:0] r_wp, r_rp;
  logic r_run;
  state_t r_state, w_nxt;
  req_t r_req, w_head;
  logic [LEN_BITS-1:0] r_beats;
  logic [BEAT_BYTES-1:0] r_mask;
  logic w_empty, w_full, w_push, w_pop, w_acc, w_last, w_done, w_mis, w_sk_rdy;
  logic [SW-1:0] w_sk_out;
  assign w_empty = r_wp == r_rp;
  assign w_full = (r_wp ^ r_rp) == {1'b1, {AW{1'b0}}};
  assign s.req_ready = r_run && !w_full;
  assign w_push = s.req_valid && s.req_ready;
  assign w_head = r_mem[r_rp[AW-1:0]];
  assign m.req_valid = r_state == REQ;
  assign m.req_data = r_req;
  assign s.tready = r_state == DATA && w_sk_rdy;
  assign w_acc = s.tvalid && s.tready;
  assign w_last = r_beats == LEN_BITS'(1);
  assign w_done = (m.req_valid && m.req_ready && r_beats == '0) || (w_acc && w_last);
  assign w_mis = w_acc && (s.tlast != w_last);
  // next state and queue pop; the next request is taken in the same cycle the current one finishes
  always_comb begin
    w_pop = !w_empty && (r_state == IDLE || w_done);
    w_nxt = w_pop ? REQ : w_done ? IDLE : (m.req_valid && m.req_ready) ? DATA : r_state;
  end
  // request queue storage; emptiness is tracked by the pointers alone
  always_ff @(posedge aclk)
    if (w_push) r_mem[r_wp[AW-1:0]] <= s.req_data;
  // queue pointers, FSM state, latched request context and sticky length error
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_run <= 1'b0;
      r_wp <= '0;
      r_rp <= '0;
      r_state <= IDLE;
      r_req <= '0;
      r_beats <= '0;
      r_mask <= '0;
      err_len <= 1'b0;
    end else begin
      r_run <= 1'b1;
      r_wp <= r_wp + {{AW{1'b0}}, w_push};
      r_rp <= r_rp + {{AW{1'b0}}, w_pop};
      r_state <= w_nxt;
      if (w_pop) begin
        r_req <= w_head;
        r_beats <= beat_cnt(w_head.len);
        r_mask <= keep_mask(w_head.len);
      end else if (w_acc) r_beats <= r_beats - LEN_BITS'(1);
      err_len <= w_mis || (err_len && !err_clr);
    end
  rdma_wr_gate_skid #(.W(SW)) u_skid (
    .aclk(aclk),
    .aresetn(aresetn),
    .i_valid(s.tvalid && r_state == DATA),
    .o_ready(w_sk_rdy),
    .i_data({s.tdata, w_last ? s.tkeep & r_mask : s.tkeep, w_last}),
    .o_valid(m.tvalid),
    .i_ready(m.tready),
    .o_data(w_sk_out)
  );
  assign {m.tdata, m.tkeep, m.tlast} = w_sk_out;
`ifdef RDMA_WR_GATE_STATS_EN
  // free-running handshake counters, wrapping at 2^32
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      stat_req_cnt <= '0;
      stat_beat_cnt <= '0;
    end else begin
      stat_req_cnt <= stat_req_cnt + {31'd0, m.req_valid && m.req_ready};
      stat_beat_cnt <= stat_beat_cnt + {31'd0, m.tvalid && m.tready};
    end
`endif
endmodule

// File: tb/tb_rdma_wr_gate_ul.sv
// tb_rdma_wr_gate_ul: randomized directed bench for rdma_wr_gate_ul against a queue-based reference model
module tb_rdma_wr_gate_ul;
  import rdma_wr_gate_ul_pkg::*;
  localparam int CW = 640;
  localparam int BW = DATA_BITS + BEAT_BYTES + 1;
  localparam int QD = 8;
  typedef struct { logic [BW-1:0] bits; int rid; } obeat_t;
  typedef struct { logic [DATA_BITS-1:0] d; logic [BEAT_BYTES-1:0] k; logic l; } ibeat_t;
  logic aclk = 1'b0, aresetn = 1'b0, err_len, err_clr = 1'b0;
`ifdef RDMA_WR_GATE_STATS_EN
  logic [31:0] stat_req_cnt, stat_beat_cnt;
`endif
  rdma_wr_gate_ul_if s_if ();
  rdma_wr_gate_ul_if m_if ();
  rdma_wr_gate_ul dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .s(s_if),
    .m(m_if),
    .err_len(err_len),
    .err_clr(err_clr)
`ifdef RDMA_WR_GATE_STATS_EN
    ,
    .stat_req_cnt(stat_req_cnt),
    .stat_beat_cnt(stat_beat_cnt)
`endif
  );
  always #5 aclk = ~aclk;
  int n_tests = 0, n_fail = 0, cyc = 0, next_id = 0, acc_id = -1, n_push = 0, n_mreq = 0, n_mbeat = 0;
  bit exp_err = 0, rdy_rand = 0, req_hold = 0, axis_hold = 0;
  req_t in_req[$], exp_req[$];
  int exp_rid[$], hs_cyc[$];
  ibeat_t in_beat[$];
  obeat_t exp_beat[$];
  obeat_t mon_e;
  ibeat_t tmp_b;
  logic p_v = 1'b0, p_r = 1'b1;
  logic [BW-1:0] p_d;
  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask
  // reference model: a request of len bytes covers ceil(len/64) beats; the last keeps only len mod 64 bytes (all if 0)
  task automatic gen_req(input int len, input bit bad, input bit ones);
    req_t r;
    int nb = (len + BEAT_BYTES - 1) / BEAT_BYTES;
    int rem = len % BEAT_BYTES;
    r.len = LEN_BITS'(len);
    r.vaddr = {$urandom, $urandom};
    r.ctl = {4'($urandom), $urandom};
    in_req.push_back(r);
    exp_req.push_back(r);
    exp_rid.push_back(next_id);
    for (int i = 0; i < nb; i++) begin
      ibeat_t b;
      logic [BEAT_BYTES-1:0] k;
      for (int w = 0; w < DATA_BITS / 32; w++) b.d[w*32 +: 32] = $urandom;
      b.k = ones ? '1 : {$urandom, $urandom};
      b.l = bad ? (i == nb - 2) : (i == nb - 1);
      k = b.k;
      if (i == nb - 1 && rem != 0) for (int j = rem; j < BEAT_BYTES; j++) k[j] = 1'b0;
      in_beat.push_back(b);
      exp_beat.push_back('{bits: {b.d, k, i == nb - 1}, rid: next_id});
      if (b.l != (i == nb - 1)) exp_err = 1;
    end
    next_id++;
  endtask
  task automatic send_reqs();
    while (in_req.size() > 0) begin
      int t = 0;
      s_if.req_data = in_req.pop_front();
      s_if.req_valid = 1'b1;
      @(negedge aclk);
      while (!s_if.req_ready && t < 3000) begin @(negedge aclk); t++; end
      if (t == 3000) check("req_accept_timeout", CW'(s_if.req_ready), CW'(1));
      @(posedge aclk); #1;
      s_if.req_valid = 1'b0;
      n_push++;
    end
  endtask
  task automatic send_beats();
    while (in_beat.size() > 0) begin
      ibeat_t b = in_beat.pop_front();
      int t = 0;
      if (rdy_rand && $urandom_range(0, 3) == 0) begin
        s_if.tvalid = 1'b0;
        @(posedge aclk); #1;
      end
      s_if.tdata = b.d;
      s_if.tkeep = b.k;
      s_if.tlast = b.l;
      s_if.tvalid = 1'b1;
      @(negedge aclk);
      while (!s_if.tready && t < 3000) begin @(negedge aclk); t++; end
      if (t == 3000) check("beat_accept_timeout", CW'(s_if.tready), CW'(1));
      @(posedge aclk); #1;
      s_if.tvalid = 1'b0;
    end
  endtask
  task automatic run_batch();
    int t = 0;
    @(posedge aclk); #1;
    fork
      send_reqs();
      send_beats();
    join
    while ((exp_req.size() > 0 || exp_beat.size() > 0) && t < 3000) begin @(negedge aclk); t++; end
    check("drain_req_left", CW'(exp_req.size()), CW'(0));
    check("drain_beat_left", CW'(exp_beat.size()), CW'(0));
    check("err_len", CW'(err_len), CW'(exp_err));
  endtask
  task automatic clr_err();
    @(posedge aclk); #1 err_clr = 1'b1;
    @(posedge aclk); #1 err_clr = 1'b0;
    exp_err = 0;
    @(negedge aclk);
    check("err_len_cleared", CW'(err_len), CW'(0));
  endtask
  // output monitor: every forwarded request and beat is matched against the model in order
  always @(negedge aclk) begin
    cyc++;
    if (aresetn && p_v && !p_r)
      check("m_axis_hold", CW'({m_if.tvalid, m_if.tdata, m_if.tkeep, m_if.tlast}), CW'({1'b1, p_d}));
    if (aresetn && m_if.req_valid && m_if.req_ready) begin
      hs_cyc.push_back(cyc);
      n_mreq++;
      check("m_req_expected", CW'(exp_req.size() > 0), CW'(1));
      if (exp_req.size() > 0) begin
        check("m_req_data", CW'(m_if.req_data), CW'(exp_req.pop_front()));
        acc_id = exp_rid.pop_front();
      end
    end
    if (aresetn && m_if.tvalid && m_if.tready) begin
      n_mbeat++;
      check("m_axis_expected", CW'(exp_beat.size() > 0), CW'(1));
      if (exp_beat.size() > 0) begin
        mon_e = exp_beat.pop_front();
        check("m_axis_beat", CW'({m_if.tdata, m_if.tkeep, m_if.tlast}), CW'(mon_e.bits));
        check("beat_after_req", CW'(acc_id >= mon_e.rid), CW'(1));
      end
    end
    p_v = aresetn && m_if.tvalid;
    p_r = m_if.tready;
    p_d = {m_if.tdata, m_if.tkeep, m_if.tlast};
  end
  // downstream ready drivers
  initial begin
    m_if.req_ready = 1'b0;
    m_if.tready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      m_if.req_ready = !req_hold && (!rdy_rand || $urandom_range(0, 3) != 0);
      m_if.tready = !axis_hold && (!rdy_rand || $urandom_range(0, 1) == 1);
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    s_if.req_valid = 1'b0;
    s_if.req_data = '0;
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    s_if.tkeep = '0;
    s_if.tlast = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_s_req_ready", CW'(s_if.req_ready), CW'(0));
    check("rst_m_req_valid", CW'(m_if.req_valid), CW'(0));
    check("rst_m_axis_tvalid", CW'(m_if.tvalid), CW'(0));
    check("rst_s_axis_tready", CW'(s_if.tready), CW'(0));
    check("rst_err_len", CW'(err_len), CW'(0));
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    check("s_req_ready_after_rst", CW'(s_if.req_ready), CW'(1));
    check("s_axis_tready_idle", CW'(s_if.tready), CW'(0));
    gen_req(128, 0, 1);
    run_batch();
    gen_req(100, 0, 1);
    run_batch();
    req_hold = 1;
    gen_req(0, 0, 1);
    gen_req(64, 0, 1);
    hs_cyc.delete();
    fork
      run_batch();
      begin
        repeat (8) @(posedge aclk);
        req_hold = 0;
      end
    join
    check("zero_len_handshakes", CW'(hs_cyc.size()), CW'(2));
    if (hs_cyc.size() == 2) check("zero_len_no_bubble", CW'(hs_cyc[1] - hs_cyc[0]), CW'(1));
    gen_req(192, 1, 0);
    run_batch();
    clr_err();
    req_hold = 1;
    n_push = 0;
    for (int i = 0; i < 12; i++) gen_req($urandom_range(1, 300), 0, 0);
    fork
      run_batch();
      begin
        repeat (40) @(posedge aclk);
        #2;
        check("queue_accepted", CW'(n_push), CW'(QD + 1));
        check("s_req_ready_full", CW'(s_if.req_ready), CW'(0));
        rdy_rand = 1;
        req_hold = 0;
      end
    join
    for (int i = 0; i < 20; i++) gen_req($urandom_range(0, 700), $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
    run_batch();
    clr_err();
    rdy_rand = 0;
    axis_hold = 1;
    gen_req(256, 0, 1);
    tmp_b = in_beat[0];
    in_beat.delete();
    in_beat.push_back(tmp_b);
    @(posedge aclk); #1;
    send_reqs();
    send_beats();
    @(negedge aclk);
    check("midburst_beat_held", CW'(m_if.tvalid), CW'(1));
    #1 aresetn = 1'b0;
    #1;
    check("async_rst_m_axis_tvalid", CW'(m_if.tvalid), CW'(0));
    check("async_rst_m_req_valid", CW'(m_if.req_valid), CW'(0));
    check("async_rst_s_axis_tready", CW'(s_if.tready), CW'(0));
    check("async_rst_s_req_ready", CW'(s_if.req_ready), CW'(0));
    in_beat.delete();
    exp_beat.delete();
    exp_req.delete();
    exp_rid.delete();
    exp_err = 0;
    n_mreq = 0;
    n_mbeat = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    axis_hold = 0;
    gen_req(64, 0, 1);
    run_batch();
`ifdef RDMA_WR_GATE_STATS_EN
    check("stat_req_cnt", CW'(stat_req_cnt), CW'(n_mreq));
    check("stat_beat_cnt", CW'(stat_beat_cnt), CW'(n_mbeat));
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
